// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard/stall controller. Produces the hold and flush controls for
// the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It covers:
//   - load-use hazards: a load in EX whose destination is read by ID
//   - control redirects resolved in EX, with extra IF/ID flush cycles for a
//     registered instruction memory
//   - data-memory wait states, with a bounded wait that raises a sticky
//     timeout flag
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall/flush
// performance counters. Without it stall_cnt/flush_cnt are tied to zero and
// no counter flops exist.
//
// Parameters
//   REDIR_EXTRA  extra IF/ID flush cycles after a redirect (0..3)
//   MAX_WAIT     dmem wait cycles before mem_timeout asserts (1..65535)
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   id_rs1_addr, id_rs2_addr    ID source register addresses
//   id_uses_rs1, id_uses_rs2    ID instruction actually reads rs1 / rs2
//   ex_rd_addr, ex_mem_read     EX destination register, EX is a load
//   ex_redirect                 EX redirects the PC this cycle
//   mem_req, dmem_ready         MEM stage dmem access and its completion
//   pc_hold, ifid_hold          PC / IF/ID keep their values
//   ifid_flush, idex_flush      IF/ID / ID/EX load a bubble
//   idex_hold, exmem_hold       ID/EX / EX/MEM keep their values
//   memwb_flush                 MEM/WB loads a bubble
//   mem_timeout                 sticky: dmem wait exceeded MAX_WAIT
//   stall_cnt, flush_cnt        performance counters (zero unless enabled)
//
// Handshake note: mem_req/dmem_ready follow valid/ready semantics -- an
// access completes on a cycle where both are high; mem_req high with
// dmem_ready low is a wait cycle that freezes the whole pipeline.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned REDIR_EXTRA = 1,
  parameter int unsigned MAX_WAIT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        dmem_ready,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        idex_hold,
  output logic        exmem_hold,
  output logic        memwb_flush,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_REDIR = 2'd1,
    S_MWAIT = 2'd2
  } state_t;

  localparam logic [1:0]  REDIR_LOAD = REDIR_EXTRA[1:0];
  // wait_cnt holds the number of wait cycles already completed, so the
  // cycle that reaches MAX_WAIT is the one where wait_cnt == MAX_WAIT-1.
  localparam logic [15:0] WAIT_LAST  = 16'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [1:0]  redir_cnt_q, redir_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;

  logic mem_wait;
  logic rs1_hit;
  logic rs2_hit;
  logic loaduse;

  assign mem_wait = mem_req & ~dmem_ready;
  assign rs1_hit  = id_uses_rs1 & (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_uses_rs2 & (id_rs2_addr == ex_rd_addr);
  assign loaduse  = ex_mem_read & (ex_rd_addr != 5'd0) & (rs1_hit | rs2_hit);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      redir_cnt_q <= 2'd0;
      wait_cnt_q  <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      redir_cnt_q <= redir_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    redir_cnt_d = redir_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;

    if (mem_wait) begin
      // Whole pipe frozen; redirect/load-use re-present once the wait clears.
      state_d = S_MWAIT;
      if (wait_cnt_q != 16'hFFFF) begin
        wait_cnt_d = wait_cnt_q + 16'd1;
      end
      if (wait_cnt_q == WAIT_LAST) begin
        timeout_d = 1'b1;
      end
    end else begin
      wait_cnt_d = 16'd0;
      if (ex_redirect) begin
        // A redirect in S_REDIR lands here too and reloads the counter.
        if (REDIR_EXTRA > 0) begin
          state_d     = S_REDIR;
          redir_cnt_d = REDIR_LOAD;
        end else begin
          state_d = S_RUN;
        end
      end else if (state_q == S_REDIR) begin
        redir_cnt_d = redir_cnt_q - 2'd1;
        state_d     = (redir_cnt_q <= 2'd1) ? S_RUN : S_REDIR;
      end else begin
        // S_RUN, or S_MWAIT with the wait released: load-use keeps us in RUN.
        state_d = S_RUN;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output logic (combinational, forced low while reset is asserted)
  // -------------------------------------------------------------------------
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    idex_hold   = 1'b0;
    exmem_hold  = 1'b0;
    memwb_flush = 1'b0;

    if (!rst) begin
      if (mem_wait) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_hold   = 1'b1;
        exmem_hold  = 1'b1;
        memwb_flush = 1'b1;
      end else if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (state_q == S_REDIR) begin
        // ID holds a bubble here, so any apparent load-use is ignored.
        ifid_flush = 1'b1;
      end else if (loaduse) begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  assign mem_timeout = timeout_q;

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (pc_hold) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (idex_flush | ifid_flush) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl (REDIR_EXTRA=1, MAX_WAIT=4). Inputs are
// driven 1 ns after a rising edge; combinational outputs are sampled on the
// falling edge. Output bundle order used in the expected vectors:
//   {pc_hold, ifid_hold, ifid_flush, idex_flush, idex_hold, exmem_hold,
//    memwb_flush}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_LDUSE  = 7'b1101000;
  localparam logic [6:0] O_REDIR0 = 7'b0011000;
  localparam logic [6:0] O_REDIR1 = 7'b0010000;
  localparam logic [6:0] O_FROZEN = 7'b1100111;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd2;
  localparam logic [31:0] EXP_FLUSH = 32'd4;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
  localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd_addr;
  logic        ex_mem_read;
  logic        ex_redirect;
  logic        mem_req;
  logic        dmem_ready;
  logic        pc_hold;
  logic        ifid_hold;
  logic        ifid_flush;
  logic        idex_flush;
  logic        idex_hold;
  logic        exmem_hold;
  logic        memwb_flush;
  logic        mem_timeout;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [6:0]  outs;

  int checks;
  int errors;

  assign outs = {pc_hold, ifid_hold, ifid_flush, idex_flush,
                 idex_hold, exmem_hold, memwb_flush};

  hazard_ctrl #(
    .REDIR_EXTRA(1),
    .MAX_WAIT   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .ex_rd_addr (ex_rd_addr),
    .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect),
    .mem_req    (mem_req),
    .dmem_ready (dmem_ready),
    .pc_hold    (pc_hold),
    .ifid_hold  (ifid_hold),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .idex_hold  (idex_hold),
    .exmem_hold (exmem_hold),
    .memwb_flush(memwb_flush),
    .mem_timeout(mem_timeout),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Checker
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_idle();
    id_rs1_addr = 5'd0;
    id_rs2_addr = 5'd0;
    id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0;
    ex_rd_addr  = 5'd0;
    ex_mem_read = 1'b0;
    ex_redirect = 1'b0;
    mem_req     = 1'b0;
    dmem_ready  = 1'b0;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [4:0] rs1,
                            input logic u1, input logic [4:0] rs2,
                            input logic u2);
    drive_idle();
    ex_mem_read = 1'b1;
    ex_rd_addr  = rd;
    id_rs1_addr = rs1;
    id_uses_rs1 = u1;
    id_rs2_addr = rs2;
    id_uses_rs2 = u2;
  endtask

  // Check outputs of the current cycle, then advance to just after the edge.
  task automatic step_chk(input string tag, input logic [6:0] exp);
    @(negedge clk);
    check_val(tag, {25'd0, outs}, {25'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive_idle();
    rst = 1'b1;

    // Reset: outputs low even with a wait presented
    @(posedge clk);
    #1;
    mem_req = 1'b1;
    step_chk("rst_outs_with_wait", O_IDLE);
    check_val("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    check_val("rst_stall_cnt", stall_cnt, 32'd0);
    check_val("rst_flush_cnt", flush_cnt, 32'd0);
    drive_idle();
    rst = 1'b0;
    step_chk("idle_after_rst", O_IDLE);

    // Load-use on rs2, then bubble
    drive_load(5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
    step_chk("lduse_rs2", O_LDUSE);
    drive_idle();
    step_chk("lduse_rs2_after", O_IDLE);

    // Load-use on rs1
    drive_load(5'd7, 5'd7, 1'b1, 5'd2, 1'b0);
    step_chk("lduse_rs1", O_LDUSE);
    drive_idle();
    step_chk("lduse_rs1_after", O_IDLE);

    // No-stall cases
    drive_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    step_chk("load_x0", O_IDLE);
    drive_load(5'd3, 5'd3, 1'b0, 5'd3, 1'b0);
    step_chk("load_no_use", O_IDLE);
    drive_idle();
    id_rs1_addr = 5'd9;
    id_uses_rs1 = 1'b1;
    ex_rd_addr  = 5'd9;
    step_chk("no_load_match", O_IDLE);

    // Redirect with one extra flush; load-use ignored in the extra cycle
    drive_idle();
    ex_redirect = 1'b1;
    step_chk("redir_c0", O_REDIR0);
    drive_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    step_chk("redir_c1_lduse_ign", O_REDIR1);
    drive_idle();
    step_chk("redir_c2", O_IDLE);

    check_val("perf_stall_cnt", stall_cnt, EXP_STALL);
    check_val("perf_flush_cnt", flush_cnt, EXP_FLUSH);

    // Redirect beats load-use; redirect in S_REDIR reloads
    drive_load(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
    ex_redirect = 1'b1;
    step_chk("redir_over_lduse", O_REDIR0);
    drive_idle();
    ex_redirect = 1'b1;
    step_chk("redir_reload", O_REDIR0);
    drive_idle();
    step_chk("redir_reload_c1", O_REDIR1);
    step_chk("redir_reload_c2", O_IDLE);

    // Wait 3 cycles with redirect pending, then redirect acts
    drive_idle();
    ex_redirect = 1'b1;
    mem_req     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_chk($sformatf("wait_frozen_%0d", i), O_FROZEN);
    end
    dmem_ready = 1'b1;
    step_chk("wait_release_redir", O_REDIR0);
    check_val("no_timeout_3", {31'd0, mem_timeout}, 32'd0);
    drive_idle();
    step_chk("wait_release_redir_c1", O_REDIR1);
    step_chk("wait_release_idle", O_IDLE);

    // Timeout after the 4th wait cycle, sticky past ready
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step_chk($sformatf("to_wait_%0d", i), O_FROZEN);
      if (i == 2) check_val("to_not_yet", {31'd0, mem_timeout}, 32'd0);
    end
    check_val("to_set", {31'd0, mem_timeout}, 32'd1);
    dmem_ready = 1'b1;
    step_chk("to_ready", O_IDLE);
    drive_idle();
    step_chk("to_idle", O_IDLE);
    check_val("to_sticky", {31'd0, mem_timeout}, 32'd1);

    // Async reset mid-redirect
    ex_redirect = 1'b1;
    @(posedge clk);
    #1;
    drive_idle();
    rst = 1'b1;
    #1;
    check_val("async_rst_outs", {25'd0, outs}, 32'd0);
    check_val("async_rst_timeout", {31'd0, mem_timeout}, 32'd0);
    check_val("async_rst_stall", stall_cnt, 32'd0);
    check_val("async_rst_flush", flush_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step_chk("post_rst_idle", O_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
